// File: rtl/uart_seq_pkg.sv
// Shared constants and types for the UART configuration/transmit sequencer.
// Register offsets follow the 16550-style map of the UART core.
package uart_seq_pkg;

    localparam logic [4:0] ADDR_THR = 5'd0;
    localparam logic [4:0] ADDR_DLL = 5'd0;
    localparam logic [4:0] ADDR_IER = 5'd1;
    localparam logic [4:0] ADDR_DLM = 5'd1;
    localparam logic [4:0] ADDR_FCR = 5'd2;
    localparam logic [4:0] ADDR_LCR = 5'd3;
    localparam logic [4:0] ADDR_LSR = 5'd5;

    localparam int LSR_THRE_BIT = 5;

    localparam logic [7:0] DLAB_MASK = 8'h80;

    // Index of the final configuration write
    localparam logic [2:0] CFG_LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        CFG,
        IDLE,
        POLL,
        WR_THR,
        ERR
    } seq_state_t;

endpackage

// File: rtl/uart_wb_sequencer_if.sv
// Wishbone register-port bundle between the sequencer (master) and the UART (slave).
interface uart_wb_sequencer_if;
    import uart_seq_pkg::*;

    logic [4:0] wb_addr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic [3:0] wb_sel_o;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;

    modport master (
        output wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/uart_wb_txn.sv
// Single-transaction Wishbone engine. A one-cycle req launches one bus cycle;
// done (with rdata) or timeout pulses for one cycle when it ends.
module uart_wb_txn
    import uart_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_wb_sequencer_if.master  wb,
    input  logic                 req,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [7:0]           wdata,
    output logic                 done,
    output logic [7:0]           rdata,
    output logic                 timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] ack_cnt;

    // Launch, hold and retire one bus cycle; the ack counter runs from stb rise
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.wb_cyc_o  <= 1'b0;
            wb.wb_stb_o  <= 1'b0;
            wb.wb_we_o   <= 1'b0;
            wb.wb_sel_o  <= 4'b0000;
            wb.wb_addr_o <= 5'd0;
            wb.wb_dat_o  <= 8'h00;
            ack_cnt      <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            rdata        <= 8'h00;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (wb.wb_stb_o) begin
                if (wb.wb_ack_i) begin
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_we_o  <= 1'b0;
                    wb.wb_sel_o <= 4'b0000;
                    rdata       <= wb.wb_dat_i;
                    done        <= 1'b1;
                end else if (ack_cnt == CNT_LAST) begin
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_we_o  <= 1'b0;
                    wb.wb_sel_o <= 4'b0000;
                    timeout     <= 1'b1;
                end else begin
                    ack_cnt <= ack_cnt + CW'(1);
                end
            end else if (req) begin
                wb.wb_cyc_o  <= 1'b1;
                wb.wb_stb_o  <= 1'b1;
                wb.wb_we_o   <= we;
                wb.wb_sel_o  <= 4'b0001;
                wb.wb_addr_o <= addr;
                wb.wb_dat_o  <= wdata;
                ack_cnt      <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_wb_sequencer.sv
// Wishbone master for the UART register port: configures the UART after reset
// (or reinit), then streams bytes to THR, polling LSR.THRE before each write.
module uart_wb_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter logic [7:0]  FCR_VAL     = 8'h07,
    parameter logic [7:0]  IER_VAL     = 8'h00,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          POLL_MAX    = 1024
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    uart_wb_sequencer_if.master  wb,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 reinit,
    output logic                 cfg_done,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    seq_state_t    state;
    logic [2:0]    step;
    logic          issued;
    logic          req;
    logic          req_we;
    logic [4:0]    req_addr;
    logic [7:0]    req_wdata;
    logic [7:0]    tx_byte;
    logic [PW-1:0] poll_cnt;

    logic          txn_done;
    logic [7:0]    txn_rdata;
    logic          txn_timeout;
    logic          unused_rdata_bits;

    function automatic logic [4:0] step_addr(input logic [2:0] s);
        case (s)
            3'd0:    return ADDR_LCR;
            3'd1:    return ADDR_DLL;
            3'd2:    return ADDR_DLM;
            3'd3:    return ADDR_LCR;
            3'd4:    return ADDR_FCR;
            3'd5:    return ADDR_IER;
            default: return ADDR_LCR;
        endcase
    endfunction

    function automatic logic [7:0] step_data(input logic [2:0] s);
        case (s)
            3'd0:    return LCR_VAL | DLAB_MASK;
            3'd1:    return DIVISOR[7:0];
            3'd2:    return DIVISOR[15:8];
            3'd3:    return LCR_VAL & ~DLAB_MASK;
            3'd4:    return FCR_VAL;
            3'd5:    return IER_VAL;
            default: return 8'h00;
        endcase
    endfunction

    uart_wb_txn #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_txn (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .wb      (wb),
        .req     (req),
        .we      (req_we),
        .addr    (req_addr),
        .wdata   (req_wdata),
        .done    (txn_done),
        .rdata   (txn_rdata),
        .timeout (txn_timeout)
    );

    // Only THRE matters from the LSR read; the rest of the byte is intentionally dropped
    assign unused_rdata_bits = ^{txn_rdata[7:LSR_THRE_BIT+1], txn_rdata[LSR_THRE_BIT-1:0]};

    // A pending reinit takes priority over a byte offered in the same cycle
    assign tx_ready = (state == IDLE) && !err && !reinit;
    assign busy     = (state != IDLE);

    // Sequencer FSM: issues one bus request at a time and reacts to done/timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= CFG;
            step      <= 3'd0;
            issued    <= 1'b0;
            req       <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 5'd0;
            req_wdata <= 8'h00;
            tx_byte   <= 8'h00;
            poll_cnt  <= '0;
            cfg_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            req <= 1'b0;
            case (state)
                CFG: begin
                    if (txn_timeout) begin
                        state  <= ERR;
                        err    <= 1'b1;
                        issued <= 1'b0;
                    end else if (!issued) begin
                        req       <= 1'b1;
                        req_we    <= 1'b1;
                        req_addr  <= step_addr(step);
                        req_wdata <= step_data(step);
                        issued    <= 1'b1;
                    end else if (txn_done) begin
                        if (step == CFG_LAST_STEP) begin
                            cfg_done <= 1'b1;
                            state    <= IDLE;
                            step     <= 3'd0;
                            issued   <= 1'b0;
                        end else begin
                            step      <= step + 3'd1;
                            req       <= 1'b1;
                            req_we    <= 1'b1;
                            req_addr  <= step_addr(step + 3'd1);
                            req_wdata <= step_data(step + 3'd1);
                        end
                    end
                end
                IDLE: begin
                    if (reinit) begin
                        state    <= CFG;
                        step     <= 3'd0;
                        issued   <= 1'b0;
                        cfg_done <= 1'b0;
                        err      <= 1'b0;
                    end else if (tx_valid && !err) begin
                        tx_byte   <= tx_data;
                        poll_cnt  <= '0;
                        state     <= POLL;
                        req       <= 1'b1;
                        req_we    <= 1'b0;
                        req_addr  <= ADDR_LSR;
                        req_wdata <= 8'h00;
                    end
                end
                POLL: begin
                    if (txn_timeout) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (txn_done) begin
                        if (txn_rdata[LSR_THRE_BIT]) begin
                            state     <= WR_THR;
                            req       <= 1'b1;
                            req_we    <= 1'b1;
                            req_addr  <= ADDR_THR;
                            req_wdata <= tx_byte;
                        end else if (poll_cnt == POLL_LAST) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            poll_cnt  <= poll_cnt + PW'(1);
                            req       <= 1'b1;
                            req_we    <= 1'b0;
                            req_addr  <= ADDR_LSR;
                            req_wdata <= 8'h00;
                        end
                    end
                end
                WR_THR: begin
                    if (txn_timeout) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (txn_done) begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    err <= 1'b1;
                    if (reinit) begin
                        state    <= CFG;
                        step     <= 3'd0;
                        issued   <= 1'b0;
                        cfg_done <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: begin
                    state <= ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Directed bench for uart_wb_sequencer with a small Wishbone UART slave model.
module tb_uart_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       reinit;
    logic       cfg_done;
    logic       busy;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] log_q[$];
    logic [7:0]  lsr_q[$];
    logic [7:0]  lsr_default;
    logic [15:0] cfg_exp[6];
    int          rd_count;
    int          stb_len;
    int          last_stb_len;
    int          sel_bad;
    int          ack_wait;
    int          stb_age;
    logic        hang_en;
    logic [13:0] hang_match;
    int          n;

    always #5 clk = ~clk;

    uart_wb_sequencer_if wb ();

    uart_wb_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .reinit   (reinit),
        .cfg_done (cfg_done),
        .busy     (busy),
        .err      (err)
    );

    function automatic logic [15:0] ent(input logic w, input logic [4:0] a, input logic [7:0] d);
        return {2'b00, w, a, d};
    endfunction

    // Slave model: acks ack_wait cycles after stb rises unless the access matches hang_match
    always @(negedge clk) begin
        if (rst) begin
            wb.wb_ack_i = 1'b0;
            wb.wb_dat_i = 8'h00;
            stb_age     = 0;
        end else if (wb.wb_stb_o && wb.wb_cyc_o) begin
            if (!wb.wb_ack_i) begin
                stb_age++;
                if (!(hang_en && ({wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o} == hang_match))
                    && stb_age >= ack_wait) begin
                    wb.wb_ack_i = 1'b1;
                    if (!wb.wb_we_o) begin
                        if (lsr_q.size() > 0) wb.wb_dat_i = lsr_q.pop_front();
                        else                  wb.wb_dat_i = lsr_default;
                    end
                end
            end
        end else begin
            wb.wb_ack_i = 1'b0;
            stb_age     = 0;
        end
    end

    // Bus monitor: logs completed accesses, strobe lengths and byte-select misuse
    always @(posedge clk) begin
        if (rst) begin
            stb_len = 0;
        end else begin
            if (wb.wb_stb_o && wb.wb_sel_o != 4'b0001) sel_bad++;
            if (!wb.wb_stb_o && wb.wb_sel_o != 4'b0000) sel_bad++;
            if (wb.wb_stb_o) stb_len++;
            else if (stb_len != 0) begin
                last_stb_len = stb_len;
                stb_len      = 0;
            end
            if (wb.wb_stb_o && wb.wb_ack_i) begin
                log_q.push_back(ent(wb.wb_we_o, wb.wb_addr_o,
                                    wb.wb_we_o ? wb.wb_dat_o : wb.wb_dat_i));
                if (!wb.wb_we_o) rd_count++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("tx_accept", {31'b0, tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic waitReady(input int budget, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!tx_ready && cnt < budget);
    endtask

    task automatic waitCfg(input int budget, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!cfg_done && cnt < budget);
    endtask

    task automatic waitErr(input int budget, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!err && cnt < budget);
    endtask

    task automatic pulseReinit();
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
    endtask

    task automatic checkCfgLog(input string tag);
        checkOutput({tag, "_count"}, log_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("%s_w%0d", tag, i),
                        (i < log_q.size()) ? log_q[i] : 16'hFFFF, cfg_exp[i]);
        end
    endtask

    initial begin
        cfg_exp[0] = ent(1'b1, 5'd3, 8'h83);
        cfg_exp[1] = ent(1'b1, 5'd0, 8'h1B);
        cfg_exp[2] = ent(1'b1, 5'd1, 8'h00);
        cfg_exp[3] = ent(1'b1, 5'd3, 8'h03);
        cfg_exp[4] = ent(1'b1, 5'd2, 8'h07);
        cfg_exp[5] = ent(1'b1, 5'd1, 8'h00);
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        reinit       = 1'b0;
        lsr_default  = 8'h60;
        ack_wait     = 1;
        hang_en      = 1'b0;
        hang_match   = '0;
        rd_count     = 0;
        last_stb_len = 0;
        sel_bad      = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cyc",      {31'b0, wb.wb_cyc_o}, 32'd0);
        checkOutput("rst_stb",      {31'b0, wb.wb_stb_o}, 32'd0);
        checkOutput("rst_we",       {31'b0, wb.wb_we_o},  32'd0);
        checkOutput("rst_sel",      {28'b0, wb.wb_sel_o}, 32'd0);
        checkOutput("rst_addr",     {27'b0, wb.wb_addr_o}, 32'd0);
        checkOutput("rst_dat",      {24'b0, wb.wb_dat_o}, 32'd0);
        checkOutput("rst_tx_ready", {31'b0, tx_ready},    32'd0);
        checkOutput("rst_cfg_done", {31'b0, cfg_done},    32'd0);
        checkOutput("rst_err",      {31'b0, err},         32'd0);
        checkOutput("rst_busy",     {31'b0, busy},        32'd1);

        // Configuration sequence after reset
        @(negedge clk);
        rst = 1'b0;
        waitCfg(200, n);
        checkOutput("cfg_done",     {31'b0, cfg_done}, 32'd1);
        checkOutput("cfg_edges",    n, 32'd19);
        checkCfgLog("cfg");
        checkOutput("cfg_tx_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("cfg_busy",     {31'b0, busy},     32'd0);

        // One byte with THRE already set
        log_q.delete();
        rd_count = 0;
        applyStimulus(8'h5A);
        waitReady(100, n);
        checkOutput("tx1_edges", n, 32'd6);
        checkOutput("tx1_count", log_q.size(), 32'd2);
        checkOutput("tx1_rd",    log_q[0], ent(1'b0, 5'd5, 8'h60));
        checkOutput("tx1_wr",    log_q[1], ent(1'b1, 5'd0, 8'h5A));

        // Three not-ready polls; tx_data changes while polling
        log_q.delete();
        rd_count = 0;
        lsr_q    = '{8'h00, 8'h00, 8'h00, 8'h20};
        applyStimulus(8'hC3);
        tx_data = 8'hFF;
        waitReady(100, n);
        checkOutput("tx2_edges",  n, 32'd15);
        checkOutput("tx2_reads",  rd_count, 32'd4);
        checkOutput("tx2_count",  log_q.size(), 32'd5);
        checkOutput("tx2_lastrd", log_q[3], ent(1'b0, 5'd5, 8'h20));
        checkOutput("tx2_wr",     log_q[4], ent(1'b1, 5'd0, 8'hC3));

        // Ack on the last permitted cycle is still accepted
        log_q.delete();
        ack_wait = 16;
        pulseReinit();
        #1;
        checkOutput("late_busy",     {31'b0, busy},     32'd1);
        checkOutput("late_cfg_clr",  {31'b0, cfg_done}, 32'd0);
        waitCfg(400, n);
        checkOutput("late_cfg_done", {31'b0, cfg_done}, 32'd1);
        checkOutput("late_err",      {31'b0, err},      32'd0);
        checkOutput("late_stb_len",  last_stb_len,      32'd16);
        checkOutput("late_count",    log_q.size(),      32'd6);
        ack_wait = 1;

        // reinit and tx_valid together in IDLE: reinit wins, byte is held off
        log_q.delete();
        @(negedge clk);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        reinit   = 1'b1;
        #1;
        checkOutput("coin_ready", {31'b0, tx_ready}, 32'd0);
        @(negedge clk);
        reinit = 1'b0;
        #1;
        checkOutput("coin_busy",  {31'b0, busy},     32'd1);
        checkOutput("coin_held",  {31'b0, tx_ready}, 32'd0);
        n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        waitReady(100, n);
        checkOutput("coin_count", log_q.size(), 32'd8);
        checkOutput("coin_first", log_q[0], cfg_exp[0]);
        checkOutput("coin_wr",    log_q[7], ent(1'b1, 5'd0, 8'h11));

        // Slave never acks the DLL write
        log_q.delete();
        hang_en    = 1'b1;
        hang_match = {1'b1, 5'd0, 8'h1B};
        pulseReinit();
        waitErr(200, n);
        checkOutput("to_err",      {31'b0, err},         32'd1);
        checkOutput("to_tx_ready", {31'b0, tx_ready},    32'd0);
        checkOutput("to_busy",     {31'b0, busy},        32'd1);
        checkOutput("to_cfg_done", {31'b0, cfg_done},    32'd0);
        checkOutput("to_cyc",      {31'b0, wb.wb_cyc_o}, 32'd0);
        checkOutput("to_stb_len",  last_stb_len,         32'd16);
        checkOutput("to_count",    log_q.size(),         32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("to_err_sticky", {31'b0, err},        32'd1);
        checkOutput("to_no_bus",     {31'b0, wb.wb_stb_o}, 32'd0);
        hang_en = 1'b0;
        log_q.delete();
        pulseReinit();
        #1;
        checkOutput("to_err_clr", {31'b0, err}, 32'd0);
        waitCfg(200, n);
        checkCfgLog("recfg");

        // LSR never reports THRE
        rd_count    = 0;
        lsr_default = 8'h00;
        applyStimulus(8'hAA);
        waitErr(4000, n);
        checkOutput("poll_err",      {31'b0, err},      32'd1);
        checkOutput("poll_reads",    rd_count,          32'd1024);
        checkOutput("poll_tx_ready", {31'b0, tx_ready}, 32'd0);
        lsr_default = 8'h60;
        pulseReinit();
        waitCfg(200, n);
        checkOutput("poll_recfg", {31'b0, cfg_done}, 32'd1);

        // Reset in the middle of a THR write
        hang_en    = 1'b1;
        hang_match = {1'b1, 5'd0, 8'h77};
        applyStimulus(8'h77);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(wb.wb_stb_o && wb.wb_we_o) && n < 50);
        checkOutput("mid_thr_stb", {31'b0, wb.wb_stb_o && wb.wb_we_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_cyc",  {31'b0, wb.wb_cyc_o}, 32'd0);
        checkOutput("mid_rst_stb",  {31'b0, wb.wb_stb_o}, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy},        32'd1);
        checkOutput("mid_rst_cfg",  {31'b0, cfg_done},    32'd0);
        @(negedge clk);
        hang_en = 1'b0;
        log_q.delete();
        rst = 1'b0;
        waitCfg(200, n);
        checkOutput("mid_cfg_edges", n, 32'd19);
        checkCfgLog("mid");

        checkOutput("sel_usage", sel_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_wb_sequencer.md
Name: uart_wb_sequencer

Overview:
- Wishbone master that owns the UART core's register port.
- After reset it runs a fixed configuration sequence: divisor latch, line control, FIFO control and interrupt enable.
- After that it accepts bytes on a valid/ready stream, polls LSR.THRE and writes each byte to THR.
- It sits between the transmit data source and the UART's wishbone slave, on the same clock as the UART.

Parameters:
- DIVISOR, 16'd27: baud divisor; DLL gets [7:0], DLM gets [15:8].
- LCR_VAL, 8'h03: line control value (8N1); bit 7 is forced in the sequence as needed.
- FCR_VAL, 8'h07: FIFO control value (enable FIFOs, clear RX/TX).
- IER_VAL, 8'h00: interrupt enable value.
- ACK_TIMEOUT, 16: maximum cycles from stb assertion to wb_ack_i before a bus error.
- POLL_MAX, 1024: maximum LSR reads per byte before a poll error.

Ports:
- wb_clk_i in 1: clock.
- wb_rst_i in 1: synchronous, active-high reset.
- wb_addr_o out 5: register address; bits [4:3] are always 0.
- wb_dat_o out 8: write data.
- wb_dat_i in 8: read data from the UART.
- wb_sel_o out 4: byte select; always 4'b0001 while stb is high, else 0.
- wb_we_o out 1: write enable.
- wb_stb_o out 1: strobe.
- wb_cyc_o out 1: bus cycle.
- wb_ack_i in 1: acknowledge.
- tx_data in 8: byte to send.
- tx_valid in 1: tx_data is valid.
- tx_ready out 1: byte accepted when tx_valid && tx_ready.
- reinit in 1: one-cycle pulse; re-run the configuration sequence.
- cfg_done out 1: high once the configuration sequence has completed.
- busy out 1: high when not in IDLE.
- err out 1: sticky error flag.

Behaviour:
- Reset:
  - All wb_* outputs, tx_ready, cfg_done and err are 0; busy is 1.
  - State goes to CFG with step index 0.
  - Reset applied mid-bus-cycle drops cyc/stb at that edge. No completion is owed.
- Bus cycle:
  - cyc, stb, we, addr, dat and sel are all registered and driven on the same edge.
  - They are held stable until a cycle in which wb_ack_i=1. At the next edge cyc/stb/we drop.
  - At least one idle cycle separates cycles, so minimum transaction length is 3 edges.
  - Read data is captured from wb_dat_i in the ack cycle.
  - wb_ack_i while stb=0 is ignored.
- Configuration writes, in order:
  1. addr 3 <- LCR_VAL|8'h80
  2. addr 0 <- DIVISOR[7:0]
  3. addr 1 <- DIVISOR[15:8]
  4. addr 3 <- LCR_VAL&8'h7F
  5. addr 2 <- FCR_VAL
  6. addr 1 <- IER_VAL
- cfg_done is set at the edge after the ack of step 6. State then goes to IDLE.
- States:
  - CFG -> IDLE.
  - IDLE: tx_ready=1 only here, only when err=0. On handshake, latch tx_data and go to POLL.
  - POLL: read addr 5 (LSR). If the captured bit 5 (THRE) is 1 -> WR_THR, else repeat POLL. The poll counter increments per read; reaching POLL_MAX reads without THRE -> ERR.
  - WR_THR: write addr 0 <- latched byte, then -> IDLE.
  - ERR: err=1, busy=1, no bus activity. Left only by reset or reinit.
- reinit:
  - Sampled only in IDLE or ERR.
  - Clears err and cfg_done and goes to CFG step 0.
  - In other states it is ignored, not queued.
  - If reinit and tx_valid coincide in IDLE, reinit wins; tx_ready is 0 that cycle.
- Ack timeout:
  - A counter starts at stb rise. If ACK_TIMEOUT edges elapse without ack, cyc/stb drop and state goes to ERR.
  - An ack exactly on the ACK_TIMEOUT-th cycle is accepted.
- tx_valid during CFG, POLL, WR_THR or ERR is held off (tx_ready=0). The byte is not lost.
- Throughput: one byte per at least 6 edges (LSR read plus THR write) when THRE is already set.

Decomposition:
- uart_seq_pkg:
  - Register address constants: THR=0, DLL=0, IER=1, DLM=1, FCR=2, LCR=3, LSR=5.
  - LSR_THRE_BIT=5.
  - DLAB mask 8'h80.
  - State enum {CFG, IDLE, POLL, WR_THR, ERR}.
- Sub-module uart_wb_txn: single-transaction Wishbone engine.
  - Inputs: req, we, addr, wdata.
  - Outputs: done, rdata, timeout.
  - Contains the ACK_TIMEOUT counter.
  - The sequencer FSM issues requests to it.

Test Plan:
- Reset, slave acks 1 cycle after stb -> exactly 6 writes in order: (3,83), (0,1B), (1,00), (3,03), (2,07), (1,00); then cfg_done=1, tx_ready=1.
- After cfg, tx_data=8'h5A with LSR returning 8'h60 -> one read of addr 5, then one write addr 0 = 5A, then tx_ready back to 1.
- LSR returns 8'h00 three times then 8'h20 -> 4 LSR reads, then THR write. tx_data changed during polling does not alter the written byte.
- Slave never acks step 2 -> stb drops after 16 cycles, err=1, tx_ready=0. reinit pulse -> err=0 and the sequence restarts at (3,83).
- LSR held 8'h00 -> err after exactly 1024 LSR reads.
- wb_rst_i asserted mid-THR-write -> wb_cyc_o=0 at the next edge, then the full config sequence re-runs.
